// File: rtl/flow_zz_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flow_zz_pkg : zigzag scan table and reader state encoding      rev 1.0
// ---------------------------------------------------------------------------
package flow_zz_pkg;

  localparam int BLK = 64;

  // Raster index for each zigzag scan position.
  localparam int ZZ [BLK] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_e;

  function automatic logic [5:0] zz_addr(input logic [5:0] pos);
    return 6'(ZZ[pos]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/flow_zz_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flow_zz_bank : 64x16 coefficient bank, raster write / zigzag read  rev 1.0
// ---------------------------------------------------------------------------
module flow_zz_bank
  import flow_zz_pkg::*;
#(
  parameter int N  = 2,
  parameter int BW = 5
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [BW-1:0]      wr_beat_i,
  input  logic [N-1:0][15:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [BW-1:0]      rd_beat_i,
  output logic [N-1:0][15:0] rd_data_o
);

  logic [15:0]        mem_q [BLK];
  logic [N-1:0][15:0] rd_data_q;
  logic [5:0]         w_wr_addr [N];
  logic [5:0]         w_rd_addr [N];

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign w_wr_addr[k] = 6'(int'(wr_beat_i) * N + k);
    assign w_rd_addr[k] = zz_addr(6'(int'(rd_beat_i) * N + k));
  end

  // Contents are deliberately not reset; validity is tracked by the top.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < N; k++) mem_q[w_wr_addr[k]] <= wr_data_i[k];
    end
    if (rd_en_i) begin
      for (int k = 0; k < N; k++) rd_data_q[k] <= mem_q[w_rd_addr[k]];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/flow_zigzag.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flow_zigzag : ping-pong raster-to-zigzag block reorder stage    rev 1.0
// ---------------------------------------------------------------------------
module flow_zigzag
  import flow_zz_pkg::*;
#(
  parameter int N = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               in_valid_i,
  input  logic [N-1:0][15:0] in_data_i,
  input  logic               in_sob_i,
  input  logic               in_eob_i,
  input  logic               in_sof_i,
  output logic               out_valid_o,
  output logic [N-1:0][15:0] out_data_o,
  output logic               out_sob_o,
  output logic               out_eob_o,
  output logic               out_sof_o,
  output logic               frame_err_o
);

  localparam int            BEATS = BLK / N;
  localparam int            BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST  = BW'(BEATS - 1);

  rd_state_e          state_q, state_d;
  logic [BW-1:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic               wb_q, wb_d, rb_q, rb_d;
  logic [1:0]         full_q, full_d, sof_tag_q, sof_tag_d;
  logic               err_q, err_d;
  logic               s1_valid_q, s1_valid_d, s1_sob_q, s1_sob_d;
  logic               s1_eob_q, s1_eob_d, s1_sof_q, s1_sof_d;
  logic               s1_bank_q, s1_bank_d;
  logic               out_valid_q, out_valid_d, out_sob_q, out_sob_d;
  logic               out_eob_q, out_eob_d, out_sof_q, out_sof_d;
  logic [N-1:0][15:0] out_data_q, out_data_d;

  logic               w_we, w_rd_issue;
  logic [BW-1:0]      w_wr_idx;
  logic [N-1:0][15:0] w_rd_data [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    flow_zz_bank #(.N(N), .BW(BW)) u_bank (
      .clk       (clk),
      .we_i      (w_we && (wb_q == 1'(b))),
      .wr_beat_i (w_wr_idx),
      .wr_data_i (in_data_i),
      .rd_en_i   (w_rd_issue && (rb_q == 1'(b))),
      .rd_beat_i (rd_cnt_q),
      .rd_data_o (w_rd_data[b])
    );
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    full_d      = full_q;
    sof_tag_d   = sof_tag_q;
    err_d       = err_q;
    s1_valid_d  = s1_valid_q;
    s1_sob_d    = s1_sob_q;
    s1_eob_d    = s1_eob_q;
    s1_sof_d    = s1_sof_q;
    s1_bank_d   = s1_bank_q;
    out_valid_d = out_valid_q;
    out_sob_d   = out_sob_q;
    out_eob_d   = out_eob_q;
    out_sof_d   = out_sof_q;
    out_data_d  = out_data_q;
    w_we        = 1'b0;
    w_wr_idx    = wr_cnt_q;
    w_rd_issue  = 1'b0;

    if (en_i) begin
      if (in_valid_i) begin
        if (full_q[wb_q]) begin
          err_d = 1'b1;
        end else begin
          // A start-of-block restarts the bank, discarding any partial block.
          if (in_sob_i) begin
            w_wr_idx        = '0;
            sof_tag_d[wb_q] = in_sof_i;
            if (wr_cnt_q != '0) err_d = 1'b1;
          end
          if (in_eob_i && (w_wr_idx != LAST)) err_d = 1'b1;
          w_we = 1'b1;
          if (w_wr_idx == LAST) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
            wr_cnt_d     = '0;
          end else begin
            wr_cnt_d = w_wr_idx + 1'b1;
          end
        end
      end

      w_rd_issue = (state_q == RD_RUN) || full_q[rb_q];
      s1_valid_d = w_rd_issue;
      s1_sob_d   = w_rd_issue && (rd_cnt_q == '0);
      s1_eob_d   = w_rd_issue && (rd_cnt_q == LAST);
      s1_sof_d   = w_rd_issue && (rd_cnt_q == '0) && sof_tag_q[rb_q];
      s1_bank_d  = rb_q;
      if (w_rd_issue) begin
        if (rd_cnt_q == LAST) begin
          full_d[rb_q] = 1'b0;
          rb_d         = ~rb_q;
          rd_cnt_d     = '0;
          state_d      = full_q[~rb_q] ? RD_RUN : RD_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          state_d  = RD_RUN;
        end
      end

      out_valid_d = s1_valid_q;
      out_sob_d   = s1_sob_q;
      out_eob_d   = s1_eob_q;
      out_sof_d   = s1_sof_q;
      out_data_d  = s1_valid_q ? w_rd_data[s1_bank_q] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RD_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      full_q      <= 2'b00;
      sof_tag_q   <= 2'b00;
      err_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sob_q    <= 1'b0;
      s1_eob_q    <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      full_q      <= full_d;
      sof_tag_q   <= sof_tag_d;
      err_q       <= err_d;
      s1_valid_q  <= s1_valid_d;
      s1_sob_q    <= s1_sob_d;
      s1_eob_q    <= s1_eob_d;
      s1_sof_q    <= s1_sof_d;
      s1_bank_q   <= s1_bank_d;
      out_valid_q <= out_valid_d;
      out_sob_q   <= out_sob_d;
      out_eob_q   <= out_eob_d;
      out_sof_q   <= out_sof_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sob_o   = out_sob_q;
  assign out_eob_o   = out_eob_q;
  assign out_sof_o   = out_sof_q;
  assign frame_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_flow_zigzag.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_flow_zigzag : directed bench for the zigzag reorder stage (N=2)  rev 1.0
// ---------------------------------------------------------------------------
module tb_flow_zigzag;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en_i = 1'b1;
  logic             in_valid_i = 1'b0;
  logic [1:0][15:0] in_data_i = '0;
  logic             in_sob_i = 1'b0;
  logic             in_eob_i = 1'b0;
  logic             in_sof_i = 1'b0;
  logic             out_valid_o;
  logic [1:0][15:0] out_data_o;
  logic             out_sob_o;
  logic             out_eob_o;
  logic             out_sof_o;
  logic             frame_err_o;

  flow_zigzag #(.N(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_sob_i    (in_sob_i),
    .in_eob_i    (in_eob_i),
    .in_sof_i    (in_sof_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_sob_o   (out_sob_o),
    .out_eob_o   (out_eob_o),
    .out_sof_o   (out_sof_o),
    .frame_err_o (frame_err_o)
  );

  always #5 clk = ~clk;

  int zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef struct {
    logic [31:0] d;
    logic        sob;
    logic        eob;
    logic        sof;
    int          c;
  } beat_t;

  beat_t       cap [$];
  int          cyc = 0;
  logic        en_prev = 1'b0;
  logic        rst_prev = 1'b0;
  logic [35:0] last_out = '0;
  int          held_err = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          rand_en = 1'b0;
  int          eob_edge = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    en_prev  <= en_i;
    rst_prev <= rst_n;
  end

  // Record each freshly registered output beat; outputs must not move when en was low.
  always @(negedge clk) begin
    if (rst_prev && en_prev && out_valid_o)
      cap.push_back('{out_data_o, out_sob_o, out_eob_o, out_sof_o, cyc});
    if (rst_prev && !en_prev &&
        ({out_valid_o, out_sob_o, out_eob_o, out_sof_o, out_data_o} != last_out))
      held_err++;
    last_out = {out_valid_o, out_sob_o, out_eob_o, out_sof_o, out_data_o};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit sob, input bit eob,
                      input bit sof, input bit e);
    @(negedge clk);
    in_valid_i = v;
    in_data_i  = d;
    in_sob_i   = sob;
    in_eob_i   = eob;
    in_sof_i   = sof;
    en_i       = e;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, rand_en ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  task automatic send_beat(input logic [31:0] d, input bit sob, input bit eob, input bit sof);
    if (rand_en) begin
      int k;
      k = $urandom_range(0, 2);
      repeat (k) step(1'b1, d, sob, eob, sof, 1'b0);
    end
    step(1'b1, d, sob, eob, sof, 1'b1);
    if (eob) eob_edge = cyc + 1;
  endtask

  // Raster-ordered block: lane k of beat b carries base + 2b + k.
  task automatic send_block(input int base, input bit sof, input int extra_eob);
    for (int b = 0; b < 32; b++)
      send_beat({16'(base + 2*b + 1), 16'(base + 2*b)}, b == 0,
                (b == 31) || (b == extra_eob), sof && (b == 0));
  endtask

  task automatic wait_beats(input int n, input string tag);
    int t;
    t = 0;
    while (cap.size() < n && t < 3000) begin
      idle();
      t++;
    end
    check(tag, 64'(cap.size() >= n), 64'd1);
  endtask

  task automatic verify_block(input string tag, input int start, input int base, input bit sof0);
    int          bad;
    logic [31:0] e;
    bad = 0;
    for (int b = 0; b < 32; b++) begin
      e = {16'(base + zz[2*b+1]), 16'(base + zz[2*b])};
      if (start + b >= cap.size()) bad++;
      else if (cap[start+b].d !== e || cap[start+b].sob !== (b == 0) ||
               cap[start+b].eob !== (b == 31) || cap[start+b].sof !== (sof0 && (b == 0)))
        bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) idle();
    rst_n = 1'b1;
    idle();
    cap.delete();
  endtask

  initial begin
    int gaps;
    int sofs;

    // Reset state
    rst_n = 1'b0;
    repeat (3) idle();
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_data",  64'(out_data_o),  64'd0);
    check("rst_sob",   64'(out_sob_o),   64'd0);
    check("rst_eob",   64'(out_eob_o),   64'd0);
    check("rst_sof",   64'(out_sof_o),   64'd0);
    check("rst_err",   64'(frame_err_o), 64'd0);
    rst_n = 1'b1;
    idle();

    // Case 1: single block, raster index as data
    cap.delete();
    send_block(0, 1'b0, -1);
    wait_beats(32, "t1_done");
    check("t1_len", 64'(cap.size()), 64'd32);
    if (cap.size() >= 32) begin
      check("t1_latency", 64'(cap[0].c), 64'(eob_edge + 2));
      check("t1_beat0",  64'(cap[0].d),  {32'd0, 16'd1, 16'd0});
      check("t1_beat1",  64'(cap[1].d),  {32'd0, 16'd16, 16'd8});
      check("t1_beat2",  64'(cap[2].d),  {32'd0, 16'd2, 16'd9});
      check("t1_beat31", 64'(cap[31].d), {32'd0, 16'd63, 16'd62});
      check("t1_sob0",   64'(cap[0].sob),  64'd1);
      check("t1_eob31",  64'(cap[31].eob), 64'd1);
    end
    verify_block("t1_block", 0, 0, 1'b0);
    check("t1_err", 64'(frame_err_o), 64'd0);

    // Case 2: three back-to-back blocks
    cap.delete();
    send_block(0, 1'b1, -1);
    send_block(100, 1'b0, -1);
    send_block(200, 1'b0, -1);
    wait_beats(96, "t2_done");
    gaps = 0;
    sofs = 0;
    for (int i = 0; i < cap.size(); i++) begin
      if (i > 0 && cap[i].c != cap[i-1].c + 1) gaps++;
      if (cap[i].sof) sofs++;
    end
    check("t2_gaps", 64'(gaps), 64'd0);
    check("t2_sof_count", 64'(sofs), 64'd1);
    verify_block("t2_blk0", 0, 0, 1'b1);
    verify_block("t2_blk1", 32, 100, 1'b0);
    verify_block("t2_blk2", 64, 200, 1'b0);
    check("t2_err", 64'(frame_err_o), 64'd0);

    // Case 3: en toggled during write and read
    repeat (5) idle();
    cap.delete();
    rand_en = 1'b1;
    send_block(0, 1'b0, -1);
    wait_beats(32, "t3_done");
    rand_en = 1'b0;
    verify_block("t3_block", 0, 0, 1'b0);
    check("t3_held", 64'(held_err), 64'd0);

    // Case 4: sob at wr_cnt=10 discards the partial block
    do_reset();
    for (int b = 0; b < 10; b++)
      send_beat({16'(500 + 2*b + 1), 16'(500 + 2*b)}, b == 0, 1'b0, 1'b0);
    check("t4_err_before", 64'(frame_err_o), 64'd0);
    send_block(300, 1'b0, -1);
    wait_beats(32, "t4_done");
    repeat (80) idle();
    check("t4_err", 64'(frame_err_o), 64'd1);
    check("t4_len", 64'(cap.size()), 64'd32);
    verify_block("t4_block", 0, 300, 1'b0);

    // Case 5: early eob on beat 20 flags but does not commit
    do_reset();
    send_block(0, 1'b0, 20);
    check("t5_err", 64'(frame_err_o), 64'd1);
    wait_beats(32, "t5_done");
    repeat (40) idle();
    check("t5_len", 64'(cap.size()), 64'd32);
    verify_block("t5_block", 0, 0, 1'b0);

    // Case 6: reset in the middle of a read
    do_reset();
    send_block(0, 1'b0, -1);
    wait_beats(13, "t6_mid");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_ctrl", 64'({out_valid_o, out_sob_o, out_eob_o, out_sof_o, frame_err_o}), 64'd0);
    check("t6_rst_data", 64'(out_data_o), 64'd0);
    rst_n = 1'b1;
    idle();
    cap.delete();
    send_block(50, 1'b0, -1);
    wait_beats(32, "t6_done");
    repeat (80) idle();
    check("t6_len", 64'(cap.size()), 64'd32);
    verify_block("t6_block", 0, 50, 1'b0);
    check("t6_err", 64'(frame_err_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
